// File: rtl/core_pkg.sv
// core_pkg: unit/op codes, scheduler state encoding and decode helpers shared by the issue scheduler.
package core_pkg;
  localparam int NUNITS = 6;
  localparam int MAX_OUTST = 4;
  localparam int OUTST_W = $clog2(MAX_OUTST + 1);
  localparam logic [2:0] UNIT_ARITH = 3'd0;
  localparam logic [2:0] UNIT_LOGIC = 3'd1;
  localparam logic [2:0] UNIT_INIT = 3'd2;
  localparam logic [2:0] UNIT_BRANCH = 3'd3;
  localparam logic [2:0] UNIT_LOAD = 3'd4;
  localparam logic [2:0] UNIT_STORE = 3'd5;
  localparam logic [2:0] ARITH_OP_ADD = 3'd0;
  localparam logic [2:0] ARITH_OP_SUB = 3'd1;
  localparam logic [2:0] LOGIC_OP_AND = 3'd0;
  localparam logic [2:0] LOGIC_OP_OR = 3'd1;
  localparam logic [1:0] BRANCH_OP_CONDBR = 2'd0;
  localparam logic [1:0] BRANCH_OP_JAL = 2'd1;
  localparam logic [1:0] BRANCH_OP_JALR = 2'd2;
  typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} sched_state_e;
  function automatic logic writes_rd(logic [2:0] unit, logic [2:0] op, logic [4:0] rd);
    return rd != 5'd0 && unit != UNIT_STORE && !(unit == UNIT_BRANCH && op[1:0] == BRANCH_OP_CONDBR);
  endfunction
  function automatic logic uses_rs1(logic [2:0] unit, logic [2:0] op);
    return unit == UNIT_ARITH || unit == UNIT_LOGIC || unit == UNIT_LOAD || unit == UNIT_STORE ||
           (unit == UNIT_BRANCH && op[1:0] != BRANCH_OP_JAL);
  endfunction
  function automatic logic uses_rs2(logic [2:0] unit, logic [2:0] op);
    return unit == UNIT_STORE || (unit == UNIT_BRANCH && op[1:0] == BRANCH_OP_CONDBR);
  endfunction
  function automatic logic [31:0] sat_inc(logic [31:0] v, logic inc);
    return v + 32'(inc && v != '1);
  endfunction
endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: decoder, issue, writeback and flush signals of issue_scheduler.
// ISSUE_PERF_EN adds the saturating performance counter outputs.
interface issue_scheduler_if;
  import core_pkg::*;
  logic i_dec_valid;
  logic o_dec_ready;
  logic [2:0] i_unit, i_op, i_func;
  logic [4:0] i_rd, i_rs1, i_rs2;
  logic [31:0] i_imm;
  logic [NUNITS-1:0] o_iss_valid, i_iss_ready;
  logic [2:0] o_iss_op, o_iss_func;
  logic [4:0] o_iss_rd, o_iss_rs1, o_iss_rs2;
  logic [31:0] o_iss_imm;
  logic i_wb_valid;
  logic [4:0] i_wb_rd;
  logic i_flush;
  logic o_busy;
`ifdef ISSUE_PERF_EN
  logic [31:0] o_perf_issued, o_perf_hazard_stalls, o_perf_unit_stalls;
`endif
  modport slave (
`ifdef ISSUE_PERF_EN
    output o_perf_issued, o_perf_hazard_stalls, o_perf_unit_stalls,
`endif
    input i_dec_valid, i_unit, i_op, i_func, i_rd, i_rs1, i_rs2, i_imm, i_iss_ready, i_wb_valid, i_wb_rd, i_flush,
    output o_dec_ready, o_iss_valid, o_iss_op, o_iss_func, o_iss_rd, o_iss_rs1, o_iss_rs2, o_iss_imm, o_busy
  );
  modport master (
`ifdef ISSUE_PERF_EN
    input o_perf_issued, o_perf_hazard_stalls, o_perf_unit_stalls,
`endif
    output i_dec_valid, i_unit, i_op, i_func, i_rd, i_rs1, i_rs2, i_imm, i_iss_ready, i_wb_valid, i_wb_rd, i_flush,
    input o_dec_ready, o_iss_valid, o_iss_op, o_iss_func, o_iss_rd, o_iss_rs1, o_iss_rs2, o_iss_imm, o_busy
  );
endinterface

// File: rtl/issue_scheduler_scoreboard.sv
// scoreboard: pending-write bit per register, in-flight write counter and RAW/WAW lookup.
module scoreboard import core_pkg::*; (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_set,
  input  logic [4:0] i_set_rd,
  input  logic       i_clr,
  input  logic [4:0] i_clr_rd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  input  logic       i_use_rs1,
  input  logic       i_use_rs2,
  input  logic       i_wr,
  output logic       o_hazard,
  output logic       o_full,
  output logic       o_idle
);
  logic [31:0] r_sb;
  logic [OUTST_W-1:0] r_outst;
  logic w_clr, w_dec;
  assign w_clr = i_clr && i_clr_rd != 5'd0;
  assign w_dec = w_clr && r_outst != '0;
  // Set is applied after clear so a same-register issue and writeback leaves the bit pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sb <= '0;
      r_outst <= '0;
    end else begin
      r_sb <= (r_sb & ~(32'(w_clr) << i_clr_rd)) | (32'(i_set) << i_set_rd);
      r_outst <= r_outst + OUTST_W'(i_set) - OUTST_W'(w_dec);
    end
  end
  assign o_hazard = (i_use_rs1 && r_sb[i_rs1]) || (i_use_rs2 && r_sb[i_rs2]) || (i_wr && r_sb[i_rd]);
  assign o_full = r_outst == OUTST_W'(MAX_OUTST);
  assign o_idle = r_outst == '0;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: single-entry hold register that issues one decoded instruction per cycle to its unit.
// Define ISSUE_PERF_EN to add issue/stall performance counters.
module issue_scheduler import core_pkg::*; (
  input logic i_clk,
  input logic i_rst_n,
  issue_scheduler_if.slave bus
);
  sched_state_e r_state, w_next;
  logic [2:0] r_unit, r_op, r_func;
  logic [4:0] r_rd, r_rs1, r_rs2;
  logic [31:0] r_imm;
  logic w_wr, w_hazard, w_full, w_idle, w_known, w_issue_ok, w_fire, w_accept;
  assign w_known = r_unit < 3'(NUNITS);
  assign w_wr = writes_rd(r_unit, r_op, r_rd);
  assign w_issue_ok = r_state == HOLD && w_known && !w_hazard && !(w_wr && w_full) && !bus.i_flush;
  assign bus.o_iss_valid = w_issue_ok ? NUNITS'(1) << r_unit : '0;
  assign w_fire = |(bus.o_iss_valid & bus.i_iss_ready);
  assign bus.o_dec_ready = !bus.i_flush && (r_state == EMPTY || (r_state == HOLD && w_fire));
  assign w_accept = bus.o_dec_ready && bus.i_dec_valid;
  assign bus.o_busy = r_state != EMPTY || !w_idle;
  assign bus.o_iss_op = r_op;
  assign bus.o_iss_func = r_func;
  assign bus.o_iss_rd = r_rd;
  assign bus.o_iss_rs1 = r_rs1;
  assign bus.o_iss_rs2 = r_rs2;
  assign bus.o_iss_imm = r_imm;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  end
  // Unknown unit codes leave HOLD without issuing.
  always_comb begin
    w_next = bus.i_flush ? (w_idle ? EMPTY : DRAIN) :
             w_accept ? HOLD :
             ((r_state == HOLD && (w_fire || !w_known)) || (r_state == DRAIN && w_idle)) ? EMPTY : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_unit, r_op, r_func, r_rd, r_rs1, r_rs2, r_imm} <= '0;
    end else if (w_accept) begin
      {r_unit, r_op, r_func} <= {bus.i_unit, bus.i_op, bus.i_func};
      {r_rd, r_rs1, r_rs2, r_imm} <= {bus.i_rd, bus.i_rs1, bus.i_rs2, bus.i_imm};
    end
  end
  scoreboard u_sb (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_set(w_fire && w_wr), .i_set_rd(r_rd),
    .i_clr(bus.i_wb_valid), .i_clr_rd(bus.i_wb_rd),
    .i_rs1(r_rs1), .i_rs2(r_rs2), .i_rd(r_rd),
    .i_use_rs1(uses_rs1(r_unit, r_op)), .i_use_rs2(uses_rs2(r_unit, r_op)), .i_wr(w_wr),
    .o_hazard(w_hazard), .o_full(w_full), .o_idle(w_idle)
  );
`ifdef ISSUE_PERF_EN
  logic [31:0] r_perf_issued, r_perf_hazard, r_perf_unit;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_perf_issued, r_perf_hazard, r_perf_unit} <= '0;
    end else begin
      r_perf_issued <= sat_inc(r_perf_issued, w_fire);
      r_perf_hazard <= sat_inc(r_perf_hazard, r_state == HOLD && w_hazard);
      r_perf_unit <= sat_inc(r_perf_unit, |bus.o_iss_valid && !w_fire);
    end
  end
  assign bus.o_perf_issued = r_perf_issued;
  assign bus.o_perf_hazard_stalls = r_perf_hazard;
  assign bus.o_perf_unit_stalls = r_perf_unit;
`endif
endmodule
